// File: rtl/sprite_motion.sv
// Multi-sprite motion engine: advances NUM_SPR position/velocity pairs once per frame_tick.
// Optional edge wrap-around is enabled by defining SPRITE_MOTION_WRAP_EN (adds the wrap_mode port).
module sprite_motion #(
   parameter int unsigned NUM_SPR  = 4,
   parameter int unsigned POS_W    = 16,
   parameter int unsigned VEL_W    = 8,
   parameter int          SCREEN_W = 800,
   parameter int          SCREEN_H = 480,
   parameter int          SPR_W    = 64,
   parameter int          SPR_H    = 64,
   parameter int unsigned IDX_W    = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1
) (
   input  logic                    clk_sys,
   input  logic                    reset,
   input  logic                    frame_tick,
   input  logic                    pause,
`ifdef SPRITE_MOTION_WRAP_EN
   input  logic                    wrap_mode,
`endif
   input  logic                    load_valid,
   output logic                    load_ready,
   input  logic [IDX_W-1:0]        load_idx,
   input  logic signed [POS_W-1:0] load_x,
   input  logic signed [POS_W-1:0] load_y,
   input  logic signed [VEL_W-1:0] load_vx,
   input  logic signed [VEL_W-1:0] load_vy,
   input  logic [IDX_W-1:0]        rd_idx,
   output logic signed [POS_W-1:0] rd_x,
   output logic signed [POS_W-1:0] rd_y,
   output logic signed [VEL_W-1:0] rd_vx,
   output logic signed [VEL_W-1:0] rd_vy,
   output logic                    busy,
   output logic                    update_done,
   output logic [NUM_SPR-1:0]      edge_hit,
   output logic                    overrun
);

   localparam int MAX_X = SCREEN_W - SPR_W;
   localparam int MAX_Y = SCREEN_H - SPR_H;
   localparam int unsigned AX_W = POS_W + VEL_W + 1;
   localparam logic signed [POS_W-1:0] MAXX_P = POS_W'(MAX_X);
   localparam logic signed [POS_W-1:0] MAXY_P = POS_W'(MAX_Y);
   localparam logic signed [POS_W:0]   MAXX_N = (POS_W+1)'(MAX_X);
   localparam logic signed [POS_W:0]   MAXY_N = (POS_W+1)'(MAX_Y);
   localparam logic signed [POS_W:0]   ONE_N  = (POS_W+1)'(1);
   localparam logic [IDX_W-1:0]        LAST_K = IDX_W'(NUM_SPR - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   k_q, k_d;
   logic               pend_q, pend_d;
   logic               start, drop, load_acc, wrap_c;

   logic signed [POS_W-1:0] x_r  [NUM_SPR];
   logic signed [POS_W-1:0] y_r  [NUM_SPR];
   logic signed [VEL_W-1:0] vx_r [NUM_SPR];
   logic signed [VEL_W-1:0] vy_r [NUM_SPR];

   logic [AX_W-1:0]         ax, ay;
   logic signed [POS_W-1:0] nx, ny;
   logic signed [VEL_W-1:0] nvx, nvy;
   logic                    hx, hy;

`ifdef SPRITE_MOTION_WRAP_EN
   assign wrap_c = wrap_mode;
`else
   assign wrap_c = 1'b0;
`endif

   assign load_acc = load_valid & load_ready;

   // One axis step: returns {edge, new position, new velocity}
   function automatic logic [AX_W-1:0] axis_step(input logic signed [POS_W-1:0] p,
                                                 input logic signed [VEL_W-1:0] v,
                                                 input logic signed [POS_W:0]   mx,
                                                 input logic                    wrap);
      logic signed [POS_W:0]   n;
      logic signed [POS_W:0]   r;
      logic signed [VEL_W-1:0] vo;
      logic                    hit;
      n   = (POS_W+1)'(p) + (POS_W+1)'(v);
      r   = n;
      vo  = v;
      hit = 1'b0;
      if (n[POS_W]) begin
         hit = 1'b1;
         if (wrap) r = n + mx + ONE_N;
         else begin
            r  = -n;
            vo = -v;
         end
      end else if (n > mx) begin
         hit = 1'b1;
         if (wrap) r = n - mx - ONE_N;
         else begin
            r  = mx + mx - n;
            vo = -v;
         end
      end
      return {hit, r[POS_W-1:0], vo};
   endfunction

   function automatic logic signed [POS_W-1:0] clamp(input logic signed [POS_W-1:0] p,
                                                     input logic signed [POS_W-1:0] mx);
      if (p[POS_W-1]) return '0;
      else if (p > mx) return mx;
      else return p;
   endfunction

   always_comb begin
      ax  = axis_step(x_r[k_q], vx_r[k_q], MAXX_N, wrap_c);
      ay  = axis_step(y_r[k_q], vy_r[k_q], MAXY_N, wrap_c);
      hx  = ax[AX_W-1];
      nx  = ax[AX_W-2:VEL_W];
      nvx = ax[VEL_W-1:0];
      hy  = ay[AX_W-1];
      ny  = ay[AX_W-2:VEL_W];
      nvy = ay[VEL_W-1:0];
   end

   always_ff @(posedge clk_sys or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         k_q     <= '0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         pend_q  <= pend_d;
      end
   end

   // A tick that coincides with an accepted load is deferred one cycle so the pass sees the load
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      pend_d  = pend_q;
      start   = 1'b0;
      drop    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pend_q) begin
               start  = 1'b1;
               pend_d = 1'b0;
               drop   = frame_tick & ~pause;
            end else if (frame_tick && !pause) begin
               if (load_acc) pend_d = 1'b1;
               else          start  = 1'b1;
            end
            if (start) begin
               state_d = RUN;
               k_d     = '0;
            end
         end
         RUN: begin
            drop = frame_tick & ~pause;
            if (k_q == LAST_K) state_d = DONE;
            else               k_d     = k_q + IDX_W'(1);
         end
         DONE: begin
            drop    = frame_tick & ~pause;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset) begin
      if (!reset) begin
         busy        <= 1'b0;
         load_ready  <= 1'b1;
         update_done <= 1'b0;
         overrun     <= 1'b0;
         edge_hit    <= '0;
      end else begin
         busy        <= (state_d == RUN);
         load_ready  <= (state_d == IDLE);
         update_done <= (state_d == DONE);
         if (drop) overrun <= 1'b1;
         if (start) edge_hit <= '0;
         else if (state_q == RUN && (hx || hy)) edge_hit[k_q] <= 1'b1;
      end
   end

   // Sprite state: loads only happen in IDLE, pass writes only in RUN
   always_ff @(posedge clk_sys or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(NUM_SPR); i++) begin
            x_r[i]  <= POS_W'((i * SPR_W) % (MAX_X + 1));
            y_r[i]  <= '0;
            vx_r[i] <= VEL_W'(1);
            vy_r[i] <= VEL_W'(1);
         end
      end else begin
         if (load_acc && (int'(load_idx) < int'(NUM_SPR))) begin
            x_r[load_idx]  <= clamp(load_x, MAXX_P);
            y_r[load_idx]  <= clamp(load_y, MAXY_P);
            vx_r[load_idx] <= load_vx;
            vy_r[load_idx] <= load_vy;
         end
         if (state_q == RUN) begin
            x_r[k_q]  <= nx;
            y_r[k_q]  <= ny;
            vx_r[k_q] <= nvx;
            vy_r[k_q] <= nvy;
         end
      end
   end

   always_ff @(posedge clk_sys or negedge reset) begin
      if (!reset) begin
         rd_x  <= '0;
         rd_y  <= '0;
         rd_vx <= '0;
         rd_vy <= '0;
      end else if (int'(rd_idx) < int'(NUM_SPR)) begin
         rd_x  <= x_r[rd_idx];
         rd_y  <= y_r[rd_idx];
         rd_vx <= vx_r[rd_idx];
         rd_vy <= vy_r[rd_idx];
      end else begin
         rd_x  <= '0;
         rd_y  <= '0;
         rd_vx <= '0;
         rd_vy <= '0;
      end
   end

endmodule

// File: tb/tb_sprite_motion.sv
// Directed bench for sprite_motion: reflection, clamping, pause, overrun, deferred tick, reset.
module tb_sprite_motion;

   logic               clk_sys = 1'b0;
   logic               reset = 1'b0;
   logic               frame_tick = 1'b0;
   logic               pause = 1'b0;
`ifdef SPRITE_MOTION_WRAP_EN
   logic               wrap_mode = 1'b0;
`endif
   logic               load_valid = 1'b0;
   logic               load_ready;
   logic [1:0]         load_idx = '0;
   logic signed [15:0] load_x = '0, load_y = '0;
   logic signed [7:0]  load_vx = '0, load_vy = '0;
   logic [1:0]         rd_idx = '0;
   logic signed [15:0] rd_x, rd_y;
   logic signed [7:0]  rd_vx, rd_vy;
   logic               busy, update_done, overrun;
   logic [3:0]         edge_hit;

   int vectors = 0;
   int errors  = 0;

   sprite_motion dut (
      .clk_sys(clk_sys), .reset(reset), .frame_tick(frame_tick), .pause(pause),
`ifdef SPRITE_MOTION_WRAP_EN
      .wrap_mode(wrap_mode),
`endif
      .load_valid(load_valid), .load_ready(load_ready), .load_idx(load_idx),
      .load_x(load_x), .load_y(load_y), .load_vx(load_vx), .load_vy(load_vy),
      .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y), .rd_vx(rd_vx), .rd_vy(rd_vy),
      .busy(busy), .update_done(update_done), .edge_hit(edge_hit), .overrun(overrun)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic step();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic rd(input int idx, output int x, output int y, output int vx, output int vy);
      rd_idx = 2'(idx);
      step();
      x  = int'(rd_x);
      y  = int'(rd_y);
      vx = int'(rd_vx);
      vy = int'(rd_vy);
   endtask

   task automatic do_load(input int idx, input int x, input int y, input int vx, input int vy);
      load_valid = 1'b1;
      load_idx   = 2'(idx);
      load_x     = 16'(x);
      load_y     = 16'(y);
      load_vx    = 8'(vx);
      load_vy    = 8'(vy);
      step();
      load_valid = 1'b0;
   endtask

   // Waits for update_done counting cycles from an already-stepped start; -1 on timeout
   task automatic wait_done(input int from, output int lat);
      lat = from;
      while (!update_done && lat < 40) begin
         step();
         lat++;
      end
      if (!update_done) lat = -1;
      step();
   endtask

   task automatic tick_wait(output int lat);
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      wait_done(1, lat);
   endtask

   task automatic test_reset();
      int ex[4] = '{0, 64, 128, 192};
      int x, y, vx, vy;
      reset = 1'b0;
      step();
      vectors++;
      if (rd_x !== 16'sd0 || rd_vx !== 8'sd0) begin
         errors++;
         $display("FAIL reset_rd: rd_x=%0d rd_vx=%0d expected 0 0", rd_x, rd_vx);
      end
      reset = 1'b1;
      vectors++;
      if ({busy, update_done, overrun, edge_hit, load_ready} !== 8'b0000_0001) begin
         errors++;
         $display("FAIL reset_flags: busy=%b done=%b ovr=%b edge=%b ready=%b expected 0 0 0 0000 1",
                  busy, update_done, overrun, edge_hit, load_ready);
      end
      for (int i = 0; i < 4; i++) begin
         rd(i, x, y, vx, vy);
         vectors++;
         if (x !== ex[i] || y !== 0 || vx !== 1 || vy !== 1) begin
            errors++;
            $display("FAIL reset_spr%0d: got (%0d,%0d,%0d,%0d) expected (%0d,0,1,1)", i, x, y, vx, vy, ex[i]);
         end
      end
   endtask

   task automatic test_reflect();
      int lat, x, y, vx, vy;
      do_load(0, 730, 100, 10, -3);
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      vectors++;
      if (busy !== 1'b1 || load_ready !== 1'b0) begin
         errors++;
         $display("FAIL run_flags: busy=%b ready=%b expected 1 0", busy, load_ready);
      end
      wait_done(1, lat);
      vectors++;
      if (lat !== 5) begin
         errors++;
         $display("FAIL reflect_latency: got %0d expected 5", lat);
      end
      rd(0, x, y, vx, vy);
      vectors++;
      if (x !== 732 || y !== 97 || vx !== -10 || vy !== -3) begin
         errors++;
         $display("FAIL reflect_spr0: got (%0d,%0d,%0d,%0d) expected (732,97,-10,-3)", x, y, vx, vy);
      end
      rd(1, x, y, vx, vy);
      vectors++;
      if (x !== 65 || y !== 1 || vx !== 1) begin
         errors++;
         $display("FAIL reflect_spr1: got (%0d,%0d,%0d) expected (65,1,1)", x, y, vx);
      end
      vectors++;
      if (edge_hit !== 4'b0001 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reflect_edge: edge=%b busy=%b expected 0001 0", edge_hit, busy);
      end
   endtask

   task automatic test_clamp();
      int lat, x, y, vx, vy;
      do_load(1, 3, 50, -5, 2);
      tick_wait(lat);
      vectors++;
      if (lat !== 5) begin
         errors++;
         $display("FAIL low_latency: got %0d expected 5", lat);
      end
      rd(1, x, y, vx, vy);
      vectors++;
      if (x !== 2 || y !== 52 || vx !== 5 || vy !== 2) begin
         errors++;
         $display("FAIL low_reflect_spr1: got (%0d,%0d,%0d,%0d) expected (2,52,5,2)", x, y, vx, vy);
      end
      rd(0, x, y, vx, vy);
      vectors++;
      if (x !== 722 || y !== 94) begin
         errors++;
         $display("FAIL low_spr0: got (%0d,%0d) expected (722,94)", x, y);
      end
      vectors++;
      if (edge_hit !== 4'b0010) begin
         errors++;
         $display("FAIL low_edge: got %b expected 0010", edge_hit);
      end
      do_load(2, -20, 10, 1, 1);
      do_load(3, 900, 500, -1, -1);
      rd(2, x, y, vx, vy);
      vectors++;
      if (x !== 0 || y !== 10) begin
         errors++;
         $display("FAIL clamp_low: got (%0d,%0d) expected (0,10)", x, y);
      end
      rd(3, x, y, vx, vy);
      vectors++;
      if (x !== 736 || y !== 416 || vx !== -1) begin
         errors++;
         $display("FAIL clamp_high: got (%0d,%0d,%0d) expected (736,416,-1)", x, y, vx);
      end
   endtask

   task automatic test_pause();
      int nbusy = 0;
      int x, y, vx, vy;
      pause = 1'b1;
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (busy) nbusy++;
         step();
      end
      pause = 1'b0;
      vectors++;
      if (nbusy !== 0 || overrun !== 1'b0) begin
         errors++;
         $display("FAIL pause: busy_cycles=%0d overrun=%b expected 0 0", nbusy, overrun);
      end
      rd(0, x, y, vx, vy);
      vectors++;
      if (x !== 722 || y !== 94) begin
         errors++;
         $display("FAIL pause_spr0: got (%0d,%0d) expected (722,94)", x, y);
      end
   endtask

   task automatic test_back_to_back();
      int lat_a, lat_b, x, y, vx, vy;
      tick_wait(lat_a);
      tick_wait(lat_b);
      vectors++;
      if (lat_a !== 5 || lat_b !== 5 || overrun !== 1'b0) begin
         errors++;
         $display("FAIL b2b: lat=%0d,%0d overrun=%b expected 5,5 0", lat_a, lat_b, overrun);
      end
      rd(0, x, y, vx, vy);
      vectors++;
      if (x !== 702 || y !== 88) begin
         errors++;
         $display("FAIL b2b_spr0: got (%0d,%0d) expected (702,88)", x, y);
      end
      rd(3, x, y, vx, vy);
      vectors++;
      if (x !== 734 || y !== 414 || edge_hit !== 4'b0000) begin
         errors++;
         $display("FAIL b2b_spr3: got (%0d,%0d) edge=%b expected (734,414) 0000", x, y, edge_hit);
      end
   endtask

   task automatic test_overrun();
      int lat, nbusy = 0;
      int x, y, vx, vy;
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      wait_done(3, lat);
      for (int i = 0; i < 8; i++) begin
         if (busy) nbusy++;
         step();
      end
      vectors++;
      if (lat !== 5 || overrun !== 1'b1 || nbusy !== 0) begin
         errors++;
         $display("FAIL overrun: lat=%0d overrun=%b extra_busy=%0d expected 5 1 0", lat, overrun, nbusy);
      end
      rd(1, x, y, vx, vy);
      vectors++;
      if (x !== 17 || y !== 58) begin
         errors++;
         $display("FAIL overrun_spr1: got (%0d,%0d) expected (17,58)", x, y);
      end
   endtask

   task automatic test_load_tick();
      int lat, x, y, vx, vy;
      load_valid = 1'b1;
      load_idx   = 2'd0;
      load_x     = 16'sd100;
      load_y     = 16'sd200;
      load_vx    = 8'sd7;
      load_vy    = -8'sd7;
      frame_tick = 1'b1;
      step();
      load_valid = 1'b0;
      frame_tick = 1'b0;
      vectors++;
      if (busy !== 1'b0 || load_ready !== 1'b1) begin
         errors++;
         $display("FAIL pend_cycle: busy=%b ready=%b expected 0 1", busy, load_ready);
      end
      step();
      vectors++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL pend_start: busy=%b expected 1", busy);
      end
      wait_done(2, lat);
      vectors++;
      if (lat !== 6) begin
         errors++;
         $display("FAIL pend_latency: got %0d expected 6", lat);
      end
      rd(0, x, y, vx, vy);
      vectors++;
      if (x !== 107 || y !== 193 || vx !== 7 || vy !== -7) begin
         errors++;
         $display("FAIL pend_spr0: got (%0d,%0d,%0d,%0d) expected (107,193,7,-7)", x, y, vx, vy);
      end
   endtask

   task automatic test_reset_mid();
      int ex[4] = '{0, 64, 128, 192};
      int x, y, vx, vy;
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
      reset = 1'b0;
      step();
      reset = 1'b1;
      vectors++;
      if ({busy, update_done, overrun, edge_hit, load_ready} !== 8'b0000_0001) begin
         errors++;
         $display("FAIL midreset_flags: busy=%b done=%b ovr=%b edge=%b ready=%b expected 0 0 0 0000 1",
                  busy, update_done, overrun, edge_hit, load_ready);
      end
      for (int i = 0; i < 4; i++) begin
         rd(i, x, y, vx, vy);
         vectors++;
         if (x !== ex[i] || y !== 0 || vx !== 1 || vy !== 1) begin
            errors++;
            $display("FAIL midreset_spr%0d: got (%0d,%0d,%0d,%0d) expected (%0d,0,1,1)", i, x, y, vx, vy, ex[i]);
         end
      end
   endtask

`ifdef SPRITE_MOTION_WRAP_EN
   task automatic test_wrap();
      int lat, x, y, vx, vy;
      wrap_mode = 1'b1;
      do_load(0, 730, 0, 10, 0);
      tick_wait(lat);
      wrap_mode = 1'b0;
      rd(0, x, y, vx, vy);
      vectors++;
      if (lat !== 5 || x !== 3 || vx !== 10 || edge_hit[0] !== 1'b1) begin
         errors++;
         $display("FAIL wrap: lat=%0d x=%0d vx=%0d edge0=%b expected 5 3 10 1", lat, x, vx, edge_hit[0]);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_reflect();
      test_clamp();
      test_pause();
      test_back_to_back();
      test_overrun();
      test_load_tick();
      test_reset_mid();
`ifdef SPRITE_MOTION_WRAP_EN
      test_wrap();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
